// File: rtl/sha3_msg_feeder_pkg.sv
// Shared constants, state encoding and byte-lane helper for the SHA3-256 message feeder.
// Byte k of a rate block sits at the MSB end of the block vector.
package sha3_pkg;

  localparam int         RATE_BYTES_256 = 136;
  localparam logic [7:0] SHA3_DS        = 8'h06;
  localparam logic [7:0] PAD_LAST       = 8'h80;

  typedef enum logic [1:0] {
    FILL        = 2'd0,
    SEND        = 2'd1,
    WAIT_NEXT   = 2'd2,
    WAIT_DIGEST = 2'd3
  } feeder_state_e;

  function automatic int unsigned byte_lsb(input int unsigned rate_bytes, input int unsigned k);
    return 8 * (rate_bytes - 1 - k);
  endfunction

endpackage

// File: rtl/sha3_msg_feeder_if.sv
// Byte-stream source side and SHA3TOP block-input side of the feeder, bundled as one bus.
interface sha3_msg_feeder_if
  import sha3_pkg::*;
#(
  parameter int RATE_BYTES = RATE_BYTES_256
);
  logic [7:0]              s_data;
  logic                    s_valid;
  logic                    s_last;
  logic                    s_ready;
  logic [8*RATE_BYTES-1:0] in_data;
  logic                    in_valid;
  logic                    more;
  logic                    hash_next;
  logic                    out_valid;
  logic                    busy;

  modport master (
    input  s_data, s_valid, s_last, hash_next, out_valid,
    output s_ready, in_data, in_valid, more, busy
  );

  modport slave (
    output s_data, s_valid, s_last, hash_next, out_valid,
    input  s_ready, in_data, in_valid, more, busy
  );
endinterface

// File: rtl/sha3_msg_feeder_assembler.sv
// Rate-block register: byte writes, in-place pad OR-in, standalone pad block and clear.
module sha3_block_assembler
  import sha3_pkg::*;
#(
  parameter int         RATE_BYTES = RATE_BYTES_256,
  parameter logic [7:0] DS_BYTE    = SHA3_DS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    pad_blk_i,
  input  logic                    wr_i,
  input  logic                    pad_i,
  input  logic [7:0]              idx_i,
  input  logic [7:0]              byte_i,
  output logic [8*RATE_BYTES-1:0] blk_o
);

  logic [8*RATE_BYTES-1:0] blk_q, blk_d;
  logic [7:0]              idx_nxt;

  assign idx_nxt = idx_i + 8'd1;

  always_comb begin
    blk_d = blk_q;
    if (clr_i) begin
      blk_d = '0;
    end else if (pad_blk_i) begin
      blk_d = '0;
      blk_d[byte_lsb(RATE_BYTES, 0) +: 8]              = DS_BYTE;
      blk_d[byte_lsb(RATE_BYTES, RATE_BYTES - 1) +: 8] = PAD_LAST;
    end else if (wr_i) begin
      for (int unsigned k = 0; k < RATE_BYTES; k++) begin
        if (idx_i == 8'(k)) blk_d[byte_lsb(RATE_BYTES, k) +: 8] = byte_i;
      end
      // Register is zero past the write pointer, so OR-ing the pad equals writing it;
      // the 0x80 goes last so a pad at the penultimate byte merges into 0x86.
      if (pad_i) begin
        for (int unsigned k = 0; k < RATE_BYTES; k++) begin
          if (idx_nxt == 8'(k)) blk_d[byte_lsb(RATE_BYTES, k) +: 8] |= DS_BYTE;
        end
        blk_d[byte_lsb(RATE_BYTES, RATE_BYTES - 1) +: 8] |= PAD_LAST;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blk_q <= '0;
    else        blk_q <= blk_d;
  end

  assign blk_o = blk_q;

endmodule

// File: rtl/sha3_msg_feeder.sv
// Packs a byte stream into SHA3-256 rate blocks with padding and paces them into SHA3TOP.
//
// state       | meaning
// FILL        | accepting message bytes into the block register
// SEND        | one-cycle in_valid strobe, more = pend_more
// WAIT_NEXT   | more=1 block issued; waiting for hash_next
// WAIT_DIGEST | final block issued; waiting for out_valid
module sha3_msg_feeder
  import sha3_pkg::*;
#(
  parameter int         RATE_BYTES = RATE_BYTES_256,
  parameter logic [7:0] DS_BYTE    = SHA3_DS
) (
  input logic               clk,
  input logic               rst_n,
  sha3_msg_feeder_if.master bus
);

  localparam logic [7:0] LAST_IDX = 8'(RATE_BYTES - 1);

  feeder_state_e state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          pend_more_q, pend_more_d;
  logic          pad_block_q, pad_block_d;
  logic          wr_en, pad_en, pad_blk_en, clr_en;
  logic [8*RATE_BYTES-1:0] blk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      cnt_q       <= 8'd0;
      pend_more_q <= 1'b0;
      pad_block_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_more_q <= pend_more_d;
      pad_block_q <= pad_block_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_more_d = pend_more_q;
    pad_block_d = pad_block_q;
    wr_en       = 1'b0;
    pad_en      = 1'b0;
    pad_blk_en  = 1'b0;
    clr_en      = 1'b0;
    unique case (state_q)
      FILL: begin
        if (bus.s_valid) begin
          wr_en = 1'b1;
          if (cnt_q == LAST_IDX) begin
            // Full block; a message ending exactly here still owes a pad-only block.
            state_d     = SEND;
            cnt_d       = 8'd0;
            pend_more_d = 1'b1;
            pad_block_d = bus.s_last;
          end else if (bus.s_last) begin
            pad_en      = 1'b1;
            state_d     = SEND;
            cnt_d       = 8'd0;
            pend_more_d = 1'b0;
            pad_block_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      SEND: begin
        state_d = pend_more_q ? WAIT_NEXT : WAIT_DIGEST;
      end
      WAIT_NEXT: begin
        if (bus.hash_next) begin
          if (pad_block_q) begin
            pad_blk_en  = 1'b1;
            pad_block_d = 1'b0;
            pend_more_d = 1'b0;
            state_d     = SEND;
          end else begin
            clr_en  = 1'b1;
            cnt_d   = 8'd0;
            state_d = FILL;
          end
        end
      end
      WAIT_DIGEST: begin
        if (bus.out_valid) begin
          clr_en  = 1'b1;
          cnt_d   = 8'd0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign bus.s_ready  = (state_q == FILL);
  assign bus.in_valid = (state_q == SEND);
  assign bus.more     = (state_q == SEND) && pend_more_q;
  assign bus.busy     = (state_q != FILL) || (cnt_q != 8'd0);
  assign bus.in_data  = blk;

  sha3_block_assembler #(
    .RATE_BYTES (RATE_BYTES),
    .DS_BYTE    (DS_BYTE)
  ) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (clr_en),
    .pad_blk_i (pad_blk_en),
    .wr_i      (wr_en),
    .pad_i     (pad_en),
    .idx_i     (cnt_q),
    .byte_i    (bus.s_data),
    .blk_o     (blk)
  );

endmodule

// File: tb/tb_sha3_msg_feeder.sv
// Directed bench for sha3_msg_feeder: padding cases, multi-block pacing, spurious strobes, mid-message reset.
module tb_sha3_msg_feeder;
  import sha3_pkg::*;

  localparam int RB = RATE_BYTES_256;
  localparam int W  = 8 * RB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  sha3_msg_feeder_if bus ();

  sha3_msg_feeder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] blocks[$];
  logic         mores[$];
  int           pcyc[$];
  logic         prev_iv = 1'b0;

  // Capture every block strobe; in_valid must never stay high two cycles running.
  always @(negedge clk) begin
    if (bus.in_valid === 1'b1) begin
      blocks.push_back(bus.in_data);
      mores.push_back(bus.more);
      pcyc.push_back(cyc);
      checks++;
      if (prev_iv) begin
        errors++;
        $display("FAIL in_valid_consecutive: high at cycle %0d and the cycle before, required single-cycle", cyc);
      end
    end
    prev_iv = (bus.in_valid === 1'b1);
  end

  function automatic logic [W-1:0] setb(input logic [W-1:0] v, input int k, input logic [7:0] b);
    v[W-1-8*k -: 8] = b;
    return v;
  endfunction

  function automatic logic [7:0] getb(input logic [W-1:0] v, input int k);
    return v[W-1-8*k -: 8];
  endfunction

  function automatic int first_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int k = 0; k < RB; k++) if (getb(a, k) !== getb(b, k)) return k;
    return -1;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic put_byte(input logic [7:0] d, input logic last);
    int t = 0;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    bus.s_last  = last;
    while (bus.s_ready !== 1'b1 && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL put_byte_timeout: s_ready=%b after %0d cycles, required 1", bus.s_ready, t);
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_blocks(input int n, input string tag);
    int t = 0;
    while (blocks.size() < n && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (blocks.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d blocks, required %0d", tag, blocks.size(), n);
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_hash_next();
    bus.hash_next = 1'b1;
    @(posedge clk); #1;
    bus.hash_next = 1'b0;
  endtask

  task automatic pulse_out_valid();
    bus.out_valid = 1'b1;
    @(posedge clk); #1;
    bus.out_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.s_data = 8'h00; bus.s_valid = 1'b0; bus.s_last = 1'b0;
    bus.hash_next = 1'b0; bus.out_valid = 1'b0;
    rst_n = 1'b0;
    idle(2);
    checks += 5;
    if (bus.s_ready !== 1'b1)  begin errors++; $display("FAIL reset_s_ready: got %b want 1", bus.s_ready); end
    if (bus.in_valid !== 1'b0) begin errors++; $display("FAIL reset_in_valid: got %b want 0", bus.in_valid); end
    if (bus.more !== 1'b0)     begin errors++; $display("FAIL reset_more: got %b want 0", bus.more); end
    if (bus.busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    if (bus.in_data !== '0)    begin errors++; $display("FAIL reset_in_data: byte0 %02h byte135 %02h want 00", getb(bus.in_data, 0), getb(bus.in_data, RB-1)); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_abc(input string tag);
    logic [W-1:0] exp;
    int n0, d;
    n0 = blocks.size();
    exp = '0;
    exp = setb(exp, 0, 8'h61);
    exp = setb(exp, 1, 8'h62);
    exp = setb(exp, 2, 8'h63);
    exp = setb(exp, 3, 8'h06);
    exp = setb(exp, RB-1, 8'h80);
    put_byte(8'h61, 1'b0);
    put_byte(8'h62, 1'b0);
    put_byte(8'h63, 1'b1);
    checks++;
    if (bus.in_valid !== 1'b1) begin errors++; $display("FAIL %s_latency: in_valid %b one cycle after last byte, want 1", tag, bus.in_valid); end
    wait_blocks(n0 + 1, tag);
    checks += 2;
    if (blocks[n0] !== exp) begin
      errors++; d = first_diff(blocks[n0], exp);
      $display("FAIL %s_block: byte %0d got %02h want %02h", tag, d, getb(blocks[n0], d), getb(exp, d));
    end
    if (mores[n0] !== 1'b0) begin errors++; $display("FAIL %s_more: got %b want 0", tag, mores[n0]); end
    checks += 2;
    if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL %s_wait_s_ready: got %b want 0", tag, bus.s_ready); end
    if (bus.busy !== 1'b1)    begin errors++; $display("FAIL %s_wait_busy: got %b want 1", tag, bus.busy); end
    pulse_out_valid();
    checks += 4;
    if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL %s_done_s_ready: got %b want 1", tag, bus.s_ready); end
    if (bus.busy !== 1'b0)    begin errors++; $display("FAIL %s_done_busy: got %b want 0", tag, bus.busy); end
    if (bus.in_data !== '0)   begin errors++; $display("FAIL %s_cleared: byte0 %02h want 00", tag, getb(bus.in_data, 0)); end
    if (blocks.size() != n0 + 1) begin errors++; $display("FAIL %s_block_count: got %0d want %0d", tag, blocks.size(), n0 + 1); end
  endtask

  task automatic test_pad_merge_135();
    logic [W-1:0] exp;
    int n0, d;
    n0 = blocks.size();
    exp = '0;
    for (int k = 0; k < RB-1; k++) exp = setb(exp, k, 8'hA5);
    exp = setb(exp, RB-1, 8'h86);
    for (int i = 0; i < RB-1; i++) put_byte(8'hA5, i == RB-2);
    wait_blocks(n0 + 1, "b135");
    checks += 2;
    if (blocks[n0] !== exp) begin
      errors++; d = first_diff(blocks[n0], exp);
      $display("FAIL b135_block: byte %0d got %02h want %02h", d, getb(blocks[n0], d), getb(exp, d));
    end
    if (mores[n0] !== 1'b0) begin errors++; $display("FAIL b135_more: got %b want 0", mores[n0]); end
    pulse_out_valid();
    idle(10);
    checks++;
    if (blocks.size() != n0 + 1) begin errors++; $display("FAIL b135_extra_block: got %0d blocks want %0d", blocks.size(), n0 + 1); end
  endtask

  task automatic test_full_136_zero();
    logic [W-1:0] exp;
    int n0, d, bad, hc;
    n0 = blocks.size();
    for (int i = 0; i < RB; i++) put_byte(8'h00, i == RB-1);
    wait_blocks(n0 + 1, "b136_1");
    checks += 2;
    if (blocks[n0] !== '0) begin
      errors++; d = first_diff(blocks[n0], '0);
      $display("FAIL b136_block1: byte %0d got %02h want 00", d, getb(blocks[n0], d));
    end
    if (mores[n0] !== 1'b1) begin errors++; $display("FAIL b136_more1: got %b want 1", mores[n0]); end
    // Hold off hash_next; a stray out_valid in WAIT_NEXT must not release anything.
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      bus.out_valid = (c == 10);
      @(posedge clk); #1;
      if (bus.s_ready !== 1'b0) bad++;
    end
    bus.out_valid = 1'b0;
    checks += 3;
    if (bad != 0) begin errors++; $display("FAIL b136_hold_s_ready: high on %0d of 30 cycles, want 0", bad); end
    if (blocks.size() != n0 + 1) begin errors++; $display("FAIL b136_hold_no_block: got %0d blocks want %0d", blocks.size(), n0 + 1); end
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL b136_hold_busy: got %b want 1", bus.busy); end
    hc = cyc;
    pulse_hash_next();
    wait_blocks(n0 + 2, "b136_2");
    exp = '0;
    exp = setb(exp, 0, 8'h06);
    exp = setb(exp, RB-1, 8'h80);
    checks += 3;
    if (blocks[n0+1] !== exp) begin
      errors++; d = first_diff(blocks[n0+1], exp);
      $display("FAIL b136_block2: byte %0d got %02h want %02h", d, getb(blocks[n0+1], d), getb(exp, d));
    end
    if (mores[n0+1] !== 1'b0) begin errors++; $display("FAIL b136_more2: got %b want 0", mores[n0+1]); end
    if (pcyc[n0+1] - hc != 1) begin errors++; $display("FAIL b136_pad_latency: got %0d cycles want 1", pcyc[n0+1] - hc); end
    pulse_out_valid();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL b136_done_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back_300();
    logic [W-1:0] e1, e2, e3;
    int n0, d, bad;
    n0 = blocks.size();
    e1 = '0; e2 = '0; e3 = '0;
    for (int k = 0; k < RB; k++) begin
      e1 = setb(e1, k, 8'(k));
      e2 = setb(e2, k, 8'(RB + k));
    end
    for (int k = 0; k < 28; k++) e3 = setb(e3, k, 8'(2*RB + k));
    e3 = setb(e3, 28, 8'h06);
    e3 = setb(e3, RB-1, 8'h80);
    for (int i = 0; i < 300; i++) begin
      idle($urandom_range(0, 2));
      put_byte(8'(i), i == 299);
      if (i == RB-1 || i == 2*RB-1) begin
        wait_blocks(n0 + (i + 1) / RB, "m300_cont");
        checks += 2;
        if (mores[blocks.size()-1] !== 1'b1) begin errors++; $display("FAIL m300_more_cont: block %0d got %b want 1", blocks.size()-n0, mores[blocks.size()-1]); end
        if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL m300_s_ready_wait: got %b want 0", bus.s_ready); end
        idle($urandom_range(0, 3));
        pulse_hash_next();
      end
    end
    wait_blocks(n0 + 3, "m300_last");
    checks += 4;
    if (blocks[n0] !== e1) begin
      errors++; d = first_diff(blocks[n0], e1);
      $display("FAIL m300_block1: byte %0d got %02h want %02h", d, getb(blocks[n0], d), getb(e1, d));
    end
    if (blocks[n0+1] !== e2) begin
      errors++; d = first_diff(blocks[n0+1], e2);
      $display("FAIL m300_block2: byte %0d got %02h want %02h", d, getb(blocks[n0+1], d), getb(e2, d));
    end
    if (blocks[n0+2] !== e3) begin
      errors++; d = first_diff(blocks[n0+2], e3);
      $display("FAIL m300_block3: byte %0d got %02h want %02h", d, getb(blocks[n0+2], d), getb(e3, d));
    end
    if (mores[n0+2] !== 1'b0) begin errors++; $display("FAIL m300_more_last: got %b want 0", mores[n0+2]); end
    // A new message offered before out_valid must be held off.
    bus.s_data = 8'h61; bus.s_valid = 1'b1; bus.s_last = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.s_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL m300_hold_next_msg: s_ready high on %0d of 10 cycles, want 0", bad); end
    pulse_out_valid();
    bus.s_valid = 1'b0;
    test_abc("m300_next");
  endtask

  task automatic test_spurious();
    logic [W-1:0] exp;
    int n0, d;
    n0 = blocks.size();
    put_byte(8'h61, 1'b0);
    put_byte(8'h62, 1'b0);
    pulse_hash_next();
    pulse_out_valid();
    checks += 3;
    if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL spur_s_ready: got %b want 1", bus.s_ready); end
    if (bus.busy !== 1'b1)    begin errors++; $display("FAIL spur_busy: got %b want 1", bus.busy); end
    if (blocks.size() != n0)  begin errors++; $display("FAIL spur_no_block: got %0d blocks want %0d", blocks.size(), n0); end
    put_byte(8'h63, 1'b1);
    wait_blocks(n0 + 1, "spur");
    exp = '0;
    exp = setb(exp, 0, 8'h61);
    exp = setb(exp, 1, 8'h62);
    exp = setb(exp, 2, 8'h63);
    exp = setb(exp, 3, 8'h06);
    exp = setb(exp, RB-1, 8'h80);
    checks++;
    if (blocks[n0] !== exp) begin
      errors++; d = first_diff(blocks[n0], exp);
      $display("FAIL spur_block: byte %0d got %02h want %02h", d, getb(blocks[n0], d), getb(exp, d));
    end
    pulse_out_valid();
  endtask

  task automatic test_reset_mid_fill();
    int n0, bad;
    n0 = blocks.size();
    for (int i = 0; i < 70; i++) put_byte(8'h11, 1'b0);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b want 1", bus.busy); end
    #3;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (bus.busy !== 1'b0)     begin errors++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
    if (bus.s_ready !== 1'b1)  begin errors++; $display("FAIL rmid_s_ready: got %b want 1", bus.s_ready); end
    if (bus.in_valid !== 1'b0) begin errors++; $display("FAIL rmid_in_valid: got %b want 0", bus.in_valid); end
    if (bus.in_data !== '0)    begin errors++; $display("FAIL rmid_in_data: byte0 %02h want 00", getb(bus.in_data, 0)); end
    bad = 0;
    repeat (3) begin @(posedge clk); #1; if (bus.in_valid !== 1'b0) bad++; end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    checks += 2;
    if (bad != 0) begin errors++; $display("FAIL rmid_in_valid_hold: high on %0d cycles want 0", bad); end
    if (blocks.size() != n0) begin errors++; $display("FAIL rmid_no_block: got %0d blocks want %0d", blocks.size(), n0); end
    test_abc("rmid_abc");
  endtask

  initial begin
    test_reset();
    test_abc("abc");
    test_pad_merge_135();
    test_full_136_zero();
    test_back_to_back_300();
    test_spurious();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
